sd_spi_master: RTL

- Byte-wide SPI mode-0 initiator that drives the SD card bus from the FPGA.
- It is the master end of the same SD_SCK / SD_MISO / chip-select path the board top hands to the middleboard. The core uses it to access SD directly when the middleboard is not mastering the bus.
- Sits between a core-side byte request/response handshake and the four SD pins.
- Includes a runtime clock divider: slow for card init (≤400 kHz), fast for data.

---
 rtl/sd_spi_master.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sd_spi_master.sv
// sd_spi_master: byte-wide SPI mode-0 master for the SD card pins.
// One byte is shifted out MSB first on SD_MOSI while a byte is shifted in
// from SD_MISO. The SCK half-period is H = div+1 clk cycles and is latched
// when a transfer starts.
// Ports:
//   clk, reset          system clock; synchronous active-high reset
//   div                 SCK half-period minus one, latched at start
//   cs_assert           chip-select request, only followed while idle
//   start, tx_data      transfer request and byte to send (start & ready)
//   ready               idle, a start will be accepted
//   rx_data, rx_valid   received byte and its one-cycle update strobe
//   SD_SCK/MOSI/MISO/CS_N  SD card SPI pins
module sd_spi_master #(
  parameter int   DIV_W     = 8,
  parameter logic IDLE_MOSI = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic             cs_assert,
  input  logic             start,
  input  logic [7:0]       tx_data,
  output logic             ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             SD_SCK,
  output logic             SD_MOSI,
  input  logic             SD_MISO,
  output logic             SD_CS_N
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] hdiv, hdiv_n;   // latched div; half-period ends when cnt == hdiv
  logic [DIV_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_cnt, bit_n;
  logic [7:0]       tx_sr, tx_n;
  logic [7:0]       rx_sr, rx_n;
  logic [7:0]       rxd_n;
  logic             sck_n, mosi_n, csn_n, rdy_n, rxv_n;
  logic             half_end;

  assign half_end = (cnt == hdiv);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hdiv     <= '0;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      ready    <= 1'b1;
      SD_SCK   <= 1'b0;
      SD_MOSI  <= IDLE_MOSI;
      SD_CS_N  <= 1'b1;
    end else begin
      state    <= state_n;
      hdiv     <= hdiv_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_n;
      tx_sr    <= tx_n;
      rx_sr    <= rx_n;
      rx_data  <= rxd_n;
      rx_valid <= rxv_n;
      ready    <= rdy_n;
      SD_SCK   <= sck_n;
      SD_MOSI  <= mosi_n;
      SD_CS_N  <= csn_n;
    end
  end

  always_comb begin
    state_n = state;
    hdiv_n  = hdiv;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    tx_n    = tx_sr;
    rx_n    = rx_sr;
    rxd_n   = rx_data;
    rxv_n   = 1'b0;
    rdy_n   = ready;
    sck_n   = SD_SCK;
    mosi_n  = SD_MOSI;
    csn_n   = SD_CS_N;
    case (state)
      // DONE behaves as IDLE for acceptance so bytes can run back to back;
      // chip select only follows cs_assert here, never mid-byte.
      IDLE, DONE: begin
        state_n = IDLE;
        csn_n   = ~cs_assert;
        sck_n   = 1'b0;
        mosi_n  = IDLE_MOSI;
        rdy_n   = 1'b1;
        if (start) begin
          state_n = LOW;
          tx_n    = tx_data;
          hdiv_n  = div;
          cnt_n   = '0;
          bit_n   = '0;
          mosi_n  = tx_data[7];
          rdy_n   = 1'b0;
        end
      end
      LOW: begin
        if (half_end) begin
          cnt_n   = '0;
          sck_n   = 1'b1;
          state_n = HIGH;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HIGH: begin
        if (half_end) begin
          // MISO sampled at the end of the high phase, just before SCK falls.
          cnt_n = '0;
          sck_n = 1'b0;
          rx_n  = {rx_sr[6:0], SD_MISO};
          if (bit_cnt == 3'd7) begin
            state_n = DONE;
            rxd_n   = rx_n;
            rxv_n   = 1'b1;
            rdy_n   = 1'b1;
            mosi_n  = IDLE_MOSI;
          end else begin
            bit_n   = bit_cnt + 3'd1;
            tx_n    = {tx_sr[6:0], 1'b0};
            mosi_n  = tx_sr[6];
            state_n = LOW;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
